pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage 8-bit pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Generates write-enable, flush, hold and bubble controls for the pipeline registers.
- Generates forwarding selects for the EX operand muxes.
- Runs a wait-state FSM that freezes the pipeline for multi-cycle data-memory accesses.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_ADDR_W, 3, register-address width (8 registers; r0 reads as zero and is never a forwarding or hazard source)
MEM_LAT, 2, data-memory access latency in cycles (legal 1..16)
CNT_W, 8, width of the stall counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
id_rs1, id_rs2  input  REG_ADDR_W  source registers of the instruction in ID
id_use_rs1, id_use_rs2  input  1  ID instruction actually reads rs1 / rs2
ex_rs1, ex_rs2  input  REG_ADDR_W  source registers of the instruction in EX
ex_dest  input  REG_ADDR_W  destination of the instruction in EX
ex_memRead  input  1  EX instruction is a load
ex_branchTaken  input  1  branch in EX resolved taken
mem_dest  input  REG_ADDR_W  destination in MEM
mem_regWrite  input  1  MEM instruction writes a register
mem_memAccess  input  1  MEM instruction is a load or store
wb_dest  input  REG_ADDR_W  destination at MEM/WB output
wb_regWrite  input  1  MEM/WB output writes a register
pc_write  output  1  PC update enable
if_id_write  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID clear to NOP
id_ex_flush  output  1  ID/EX clear to bubble
ex_mem_hold  output  1  EX/MEM hold current contents
mem_wb_bubble  output  1  MEM/WB loads bubble (regWrite=0)
fwdA, fwdB  output  2  EX operand select: 00 regfile, 10 EX/MEM aluResult, 01 MEM/WB writeback data
stall_cnt  output  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset (rst=0, asynchronous, any state including mid-wait):
  - state=RUN, wait_cnt=0, stall_cnt=0.
  - Outputs forced to: pc_write=0, if_id_write=0, flushes=0, ex_mem_hold=0, mem_wb_bubble=0, fwdA=fwdB=00.
  - After release, normal operation starts the next edge.
- FSM states: RUN, MEM_WAIT. wait_cnt is a 4-bit down-counter.
- RUN, mem_memAccess=1 and MEM_LAT>=2 (entry cycle):
  - Hold asserted: pc_write=0, if_id_write=0, ex_mem_hold=1, mem_wb_bubble=1.
  - No flushes; branch and load-use are ignored this cycle.
  - wait_cnt<=MEM_LAT-2, state<=MEM_WAIT.
- MEM_WAIT:
  - wait_cnt!=0: same hold outputs, wait_cnt decrements.
  - wait_cnt==0 (release cycle): all enables 1, no hold or bubble, state<=RUN.
  - Release cycle applies the RUN hazard rules below, except that mem_memAccess does not retrigger the wait.
  - Total hold cycles per access = MEM_LAT-1. MEM_LAT=1 never enters MEM_WAIT.
- RUN, no memory hold, priority order:
  - (1) ex_branchTaken=1: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1. Branch beats load-use in the same cycle, because the ID instruction is squashed.
  - (2) Load-use: ex_memRead & ex_dest!=0 & ((id_use_rs1 & id_rs1==ex_dest) | (id_use_rs2 & id_rs2==ex_dest)). Response: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle.
  - (3) Otherwise: pc_write=1, if_id_write=1, no flush.
- Forwarding (combinational, evaluated every cycle including hold cycles):
  - fwdA=10 if mem_regWrite & mem_dest!=0 & mem_dest==ex_rs1.
  - Else fwdA=01 if wb_regWrite & wb_dest!=0 & wb_dest==ex_rs1.
  - Else fwdA=00.
  - fwdB is identical using ex_rs2. EX/MEM has priority over MEM/WB.
- stall_cnt:
  - Increments on each rising edge where pc_write=0 while out of reset.
  - Saturates at all-ones, with no wrap.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs at reset values, stall_cnt=0. Assert rst=0 mid-MEM_WAIT (MEM_LAT=4) -> state RUN immediately, pc_write=0 while low, pc_write=1 the first cycle after release.
- Load-use: ex_memRead=1, ex_dest=3, id_rs2=3, id_use_rs2=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt +1. Repeat with ex_dest=0 -> no stall.
- Forwarding: ex_rs1=ex_rs2=5, mem_dest=5, mem_regWrite=1, wb_dest=5, wb_regWrite=1 -> fwdA=fwdB=10. Drop mem_regWrite -> 01. ex_rs1=0 with all dests 0 -> 00.
- Memory wait, MEM_LAT=3: mem_memAccess=1 in RUN -> exactly 2 hold cycles (ex_mem_hold=1, mem_wb_bubble=1, pc_write=0), then release cycle with pc_write=1; stall_cnt=2. MEM_LAT=1 -> zero hold cycles.
- Simultaneous events: ex_branchTaken=1 with a load-use match -> flushes only, pc_write=1. ex_branchTaken=1 on the MEM_WAIT entry cycle -> hold only, no flush; the branch takes effect in the release cycle.
- Saturation: force 300 stall cycles with CNT_W=8 -> stall_cnt holds at 255.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side register/status observations in,
// register enables, flushes, forwarding selects and stall counter out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 8
);
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2;
  logic                  id_use_rs1, id_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_dest;
  logic                  ex_memRead, ex_branchTaken;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_regWrite, mem_memAccess;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  wb_regWrite;

  logic                  pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic                  ex_mem_hold, mem_wb_bubble;
  logic [1:0]            fwdA, fwdB;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rs1, ex_rs2, ex_dest, ex_memRead, ex_branchTaken,
           mem_dest, mem_regWrite, mem_memAccess, wb_dest, wb_regWrite,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush,
           ex_mem_hold, mem_wb_bubble, fwdA, fwdB, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rs1, ex_rs2, ex_dest, ex_memRead, ex_branchTaken,
           mem_dest, mem_regWrite, mem_memAccess, wb_dest, wb_regWrite,
    output pc_write, if_id_write, if_id_flush, id_ex_flush,
           ex_mem_hold, mem_wb_bubble, fwdA, fwdB, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: branch flush, load-use
// stall, multi-cycle memory wait-state freeze, operand forwarding, stall counter.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 3,
  parameter int MEM_LAT    = 2,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam bit          LONG_MEM    = (MEM_LAT >= 2);
  localparam int          WAIT_INIT_I = (MEM_LAT >= 2) ? (MEM_LAT - 2) : 0;
  localparam logic [3:0]  WAIT_INIT   = WAIT_INIT_I[3:0];

  state_t           state;
  logic [3:0]       wait_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic       load_use, mem_entry, holding;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic       ex_mem_hold, mem_wb_bubble;
  logic [1:0] fwd_a, fwd_b;

  // r0 is hard-wired zero, so it is never a forwarding source
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] mem_d,
    input logic                  mem_w,
    input logic [REG_ADDR_W-1:0] wb_d,
    input logic                  wb_w
  );
    if (mem_w && (mem_d != '0) && (mem_d == src)) return 2'b10;
    if (wb_w && (wb_d != '0) && (wb_d == src))    return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    load_use  = hz.ex_memRead && (hz.ex_dest != '0) &&
                ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_dest)) ||
                 (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_dest)));
    mem_entry = LONG_MEM && (state == RUN) && hz.mem_memAccess;
    holding   = mem_entry || ((state == MEM_WAIT) && (wait_cnt != 4'd0));
  end

  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    fwd_a         = 2'b00;
    fwd_b         = 2'b00;
    if (rst) begin
      fwd_a = fwd_sel(hz.ex_rs1, hz.mem_dest, hz.mem_regWrite, hz.wb_dest, hz.wb_regWrite);
      fwd_b = fwd_sel(hz.ex_rs2, hz.mem_dest, hz.mem_regWrite, hz.wb_dest, hz.wb_regWrite);
      // A memory freeze masks branch and load-use; the branch is seen again on release
      if (holding) begin
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (hz.ex_branchTaken) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= 4'd0;
      stall_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      case (state)
        RUN: begin
          if (mem_entry) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt == 4'd0) state <= RUN;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign hz.pc_write      = pc_write;
  assign hz.if_id_write   = if_id_write;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.ex_mem_hold   = ex_mem_hold;
  assign hz.mem_wb_bubble = mem_wb_bubble;
  assign hz.fwdA          = fwd_a;
  assign hz.fwdB          = fwd_b;
  assign hz.stall_cnt     = stall_cnt;

endmodule
